// File: rtl/free_list.sv
// Circular FIFO of free physical register IDs: feeds the FRAT fresh destinations
// and reclaims IDs released by the RRAT at retire.
module free_list #(
  parameter int PREG_W   = 6,
  parameter int NUM_PREG = 64,
  parameter int NUM_AREG = 32,
  parameter int DEPTH    = NUM_PREG - NUM_AREG,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SYS,
  input  logic              Shift_IN_FRAT,
  input  logic              STALL_IN_FRAT,
  input  logic [PREG_W-1:0] RegID_IN_RRAT,
  input  logic              enable_IN_RRAT,
  output logic [PREG_W-1:0] RegID_OUT_FRAT,
  output logic              STALL_OUT_FRAT,
  output logic [CNT_W-1:0]  count_OUT,
  output logic              overflow_ERR
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic flush, empty, full, push_req, pop_ok, push_ok;

  // Explicit wrap so a non-power-of-two DEPTH still cycles correctly.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    flush    = RESET | SYS;
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    // Phys 0 backs $zero and must never re-enter the list.
    push_req = enable_IN_RRAT & (|RegID_IN_RRAT);
    pop_ok   = Shift_IN_FRAT & ~STALL_IN_FRAT & ~empty;
    push_ok  = push_req & ~full;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q | (push_req & full);
    if (pop_ok)  head_d = inc_ptr(head_q);
    if (push_ok) tail_d = inc_ptr(tail_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PREG_W'(NUM_AREG + i);
    end else if (push_ok) begin
      mem_q[tail_q] <= RegID_IN_RRAT;
    end
  end

  assign RegID_OUT_FRAT = mem_q[head_q];
  assign STALL_OUT_FRAT = empty;
  assign count_OUT      = count_q;
  assign overflow_ERR   = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized traffic against a queue model.
module tb_free_list;

  localparam int DEPTH = 32;

  logic       CLK = 1'b0;
  logic       RESET, SYS, Shift_IN_FRAT, STALL_IN_FRAT, enable_IN_RRAT;
  logic [5:0] RegID_IN_RRAT;
  logic [5:0] RegID_OUT_FRAT;
  logic       STALL_OUT_FRAT;
  logic [5:0] count_OUT;
  logic       overflow_ERR;

  int total = 0;
  int bad   = 0;

  logic [5:0] q[$];
  logic       m_ovf;

  free_list dut (
    .CLK(CLK), .RESET(RESET), .SYS(SYS),
    .Shift_IN_FRAT(Shift_IN_FRAT), .STALL_IN_FRAT(STALL_IN_FRAT),
    .RegID_IN_RRAT(RegID_IN_RRAT), .enable_IN_RRAT(enable_IN_RRAT),
    .RegID_OUT_FRAT(RegID_OUT_FRAT), .STALL_OUT_FRAT(STALL_OUT_FRAT),
    .count_OUT(count_OUT), .overflow_ERR(overflow_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    RESET = 0; SYS = 0; Shift_IN_FRAT = 0; STALL_IN_FRAT = 0;
    enable_IN_RRAT = 0; RegID_IN_RRAT = '0;
  endtask

  // Advance the model by the current inputs, then clock the DUT and settle.
  task automatic tick();
    bit pop, push;
    if (RESET || SYS) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(6'(32 + i));
      m_ovf = 0;
    end else begin
      pop  = Shift_IN_FRAT && !STALL_IN_FRAT && q.size() != 0;
      push = enable_IN_RRAT && RegID_IN_RRAT != 0 && q.size() != DEPTH;
      if (enable_IN_RRAT && RegID_IN_RRAT != 0 && q.size() == DEPTH) m_ovf = 1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(RegID_IN_RRAT);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle(); RESET = 1; tick(); tick(); RESET = 0; #1;
    total++; if (RegID_OUT_FRAT !== 6'd32) begin bad++; $display("FAIL reset_head got=%0d exp=32", RegID_OUT_FRAT); end
    total++; if (count_OUT !== 6'd32) begin bad++; $display("FAIL reset_count got=%0d exp=32", count_OUT); end
    total++; if (STALL_OUT_FRAT !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", STALL_OUT_FRAT); end
    total++; if (overflow_ERR !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_ERR); end
  endtask

  task automatic test_pop_all();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (RegID_OUT_FRAT !== 6'(32 + i)) begin bad++; $display("FAIL pop_all_id[%0d] got=%0d exp=%0d", i, RegID_OUT_FRAT, 32 + i); end
      Shift_IN_FRAT = 1; tick();
    end
    Shift_IN_FRAT = 0;
    total++; if (count_OUT !== 6'd0) begin bad++; $display("FAIL pop_all_count got=%0d exp=0", count_OUT); end
    total++; if (STALL_OUT_FRAT !== 1'b1) begin bad++; $display("FAIL pop_all_stall got=%b exp=1", STALL_OUT_FRAT); end
    Shift_IN_FRAT = 1; tick(); Shift_IN_FRAT = 0;
    total++; if (count_OUT !== 6'd0 || STALL_OUT_FRAT !== 1'b1) begin bad++; $display("FAIL pop_empty count=%0d stall=%b exp=0/1", count_OUT, STALL_OUT_FRAT); end
  endtask

  task automatic test_push_zero();
    idle();
    enable_IN_RRAT = 1;
    RegID_IN_RRAT = 6'd5; tick();
    total++; if (RegID_OUT_FRAT !== 6'd5) begin bad++; $display("FAIL push_empty_head got=%0d exp=5", RegID_OUT_FRAT); end
    RegID_IN_RRAT = 6'd0; tick();
    RegID_IN_RRAT = 6'd7; tick();
    idle();
    total++; if (count_OUT !== 6'd2) begin bad++; $display("FAIL push_zero_count got=%0d exp=2", count_OUT); end
    total++; if (RegID_OUT_FRAT !== 6'd5) begin bad++; $display("FAIL push_zero_first got=%0d exp=5", RegID_OUT_FRAT); end
    Shift_IN_FRAT = 1; tick();
    total++; if (RegID_OUT_FRAT !== 6'd7) begin bad++; $display("FAIL push_zero_second got=%0d exp=7", RegID_OUT_FRAT); end
    tick(); Shift_IN_FRAT = 0;
    total++; if (count_OUT !== 6'd0 || STALL_OUT_FRAT !== 1'b1) begin bad++; $display("FAIL push_zero_drain count=%0d stall=%b exp=0/1", count_OUT, STALL_OUT_FRAT); end
    // Empty with push and pop together: pop is refused, pushed ID shows next cycle.
    enable_IN_RRAT = 1; RegID_IN_RRAT = 6'd11; Shift_IN_FRAT = 1; tick(); idle();
    total++; if (count_OUT !== 6'd1 || RegID_OUT_FRAT !== 6'd11) begin bad++; $display("FAIL empty_both count=%0d head=%0d exp=1/11", count_OUT, RegID_OUT_FRAT); end
    Shift_IN_FRAT = 1; tick(); idle();
  endtask

  task automatic test_wrap();
    idle();
    enable_IN_RRAT = 1;
    for (int i = 0; i < 10; i++) begin RegID_IN_RRAT = 6'(10 + i); tick(); end
    total++; if (count_OUT !== 6'd10) begin bad++; $display("FAIL wrap_fill got=%0d exp=10", count_OUT); end
    RegID_IN_RRAT = 6'd40; Shift_IN_FRAT = 1;
    for (int i = 0; i < 20; i++) begin
      total++; if (RegID_OUT_FRAT !== q[0]) begin bad++; $display("FAIL wrap_head[%0d] got=%0d exp=%0d", i, RegID_OUT_FRAT, q[0]); end
      tick();
      total++; if (count_OUT !== 6'd10) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=10", i, count_OUT); end
    end
    idle();
    total++; if (RegID_OUT_FRAT !== 6'd40) begin bad++; $display("FAIL wrap_final_head got=%0d exp=40", RegID_OUT_FRAT); end
  endtask

  task automatic test_full();
    idle(); RESET = 1; tick(); idle();
    enable_IN_RRAT = 1; RegID_IN_RRAT = 6'd9; tick();
    total++; if (overflow_ERR !== 1'b1 || count_OUT !== 6'd32) begin bad++; $display("FAIL full_push ovf=%b count=%0d exp=1/32", overflow_ERR, count_OUT); end
    Shift_IN_FRAT = 1; tick(); idle();
    total++; if (count_OUT !== 6'd31 || RegID_OUT_FRAT !== 6'd33) begin bad++; $display("FAIL full_both count=%0d head=%0d exp=31/33", count_OUT, RegID_OUT_FRAT); end
    tick();
    total++; if (overflow_ERR !== 1'b1) begin bad++; $display("FAIL full_sticky got=%b exp=1", overflow_ERR); end
    // Drain to the pushed 9? No: it was rejected, so the tail must still hold 63.
    Shift_IN_FRAT = 1;
    for (int i = 0; i < 30; i++) tick();
    Shift_IN_FRAT = 0;
    total++; if (RegID_OUT_FRAT !== 6'd63 || count_OUT !== 6'd1) begin bad++; $display("FAIL full_tail head=%0d count=%0d exp=63/1", RegID_OUT_FRAT, count_OUT); end
  endtask

  task automatic test_flush(input bit use_sys);
    idle();
    Shift_IN_FRAT = 1;
    for (int i = 0; i < 12; i++) tick();
    total++; if (count_OUT !== 6'(q.size())) begin bad++; $display("FAIL flush_pre count=%0d exp=%0d", count_OUT, q.size()); end
    enable_IN_RRAT = 1; RegID_IN_RRAT = 6'd3;
    if (use_sys) SYS = 1; else RESET = 1;
    tick(); idle();
    total++; if (count_OUT !== 6'd32 || RegID_OUT_FRAT !== 6'd32) begin bad++; $display("FAIL flush_%s count=%0d head=%0d exp=32/32", use_sys ? "sys" : "rst", count_OUT, RegID_OUT_FRAT); end
    total++; if (overflow_ERR !== 1'b0 || STALL_OUT_FRAT !== 1'b0) begin bad++; $display("FAIL flush_flags ovf=%b stall=%b exp=0/0", overflow_ERR, STALL_OUT_FRAT); end
  endtask

  task automatic test_random();
    idle(); RESET = 1; tick(); idle();
    for (int i = 0; i < 600; i++) begin
      // First third leans toward popping, the rest toward pushing, to hit both bounds.
      Shift_IN_FRAT  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      STALL_IN_FRAT  = ($urandom_range(0, 4) == 0);
      enable_IN_RRAT = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      RegID_IN_RRAT  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      SYS            = ($urandom_range(0, 149) == 0);
      tick();
      total++; if (count_OUT !== 6'(q.size())) begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, count_OUT, q.size()); end
      total++; if (STALL_OUT_FRAT !== (q.size() == 0)) begin bad++; $display("FAIL rand_stall[%0d] got=%b exp=%b", i, STALL_OUT_FRAT, q.size() == 0); end
      total++; if (overflow_ERR !== m_ovf) begin bad++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", i, overflow_ERR, m_ovf); end
      if (q.size() != 0) begin
        total++; if (RegID_OUT_FRAT !== q[0]) begin bad++; $display("FAIL rand_head[%0d] got=%0d exp=%0d", i, RegID_OUT_FRAT, q[0]); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    m_ovf = 0;
    test_reset();
    test_pop_all();
    test_push_zero();
    test_wrap();
    test_full();
    test_flush(1'b1);
    test_flush(1'b0);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
